// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan receiver: glyph table, FSM states, anode classes.
package seg7_pkg;

    // Active-low a-g patterns, bit order {g,f,e,d,c,b,a}; lowercase b and d.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_e;

    typedef enum logic [1:0] {AN_NONE, AN_ONE, AN_MULTI} anode_cls_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: active-low a-g pattern to {nibble, blank, bad}; bad and blank give nibble 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       blank_o,
    output logic       bad_o
);

    always_comb begin
        nib_o   = '0;
        blank_o = (seg_i == SEG_BLANK);
        bad_o   = (seg_i != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg_i == HEX_GLYPH[i]) begin
                nib_o = 4'(i);
                bad_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive 7-segment scan receiver: syncs anodes/cathodes, captures settled digits into slots,
// publishes complete frames with a one-cycle frame_valid; sticky anode/stall error flags.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int STALL_CYCLES  = 200_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_button,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            cathodes,
    output logic [4*DIGITS-1:0]   frame_hex,
    output logic [DIGITS-1:0]     frame_dp,
    output logic [DIGITS-1:0]     frame_blank,
    output logic [DIGITS-1:0]     frame_bad,
    output logic                  frame_valid,
    output logic                  anode_err,
    output logic                  stall_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(STALL_CYCLES + 1);

    logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q, ref_an_q, ref_an_d;
    logic [7:0]          ca_s1_q, ca_s2_q, ref_ca_q, ref_ca_d;
    logic [IW-1:0]       idx_q, idx_d, hit_idx;
    state_e              state_q, state_d;
    anode_cls_e          cls;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]       stall_cnt_q, stall_cnt_d;
    logic                stall_lock_q, stall_lock_d, stall_hit;
    logic [DIGITS-1:0]   mask_q, mask_d, inv;
    logic [4*DIGITS-1:0] buf_hex_q, buf_hex_d, frame_hex_q, frame_hex_d;
    logic [DIGITS-1:0]   buf_dp_q, buf_dp_d, buf_blank_q, buf_blank_d, buf_bad_q, buf_bad_d;
    logic [DIGITS-1:0]   frame_dp_q, frame_dp_d, frame_blank_q, frame_blank_d;
    logic [DIGITS-1:0]   frame_bad_q, frame_bad_d;
    logic                frame_valid_d, frame_valid_q;
    logic                anode_err_q, anode_err_d, stall_err_q, stall_err_d;
    logic                wr_en, load;
    logic [3:0]          dec_nib;
    logic                dec_blank, dec_bad;

    seg7_decode u_decode (
        .seg_i   (ca_s2_q[6:0]),
        .nib_o   (dec_nib),
        .blank_o (dec_blank),
        .bad_o   (dec_bad)
    );

    always_comb begin
        inv     = ~an_s2_q;
        cls     = AN_NONE;
        hit_idx = '0;
        if (inv != '0) cls = ((inv & (inv - 1'b1)) == '0) ? AN_ONE : AN_MULTI;
        for (int i = 0; i < DIGITS; i++) begin
            if (inv[i]) hit_idx = IW'(i);
        end
    end

    // The stall lock keeps the FSM parked until the anode actually moves.
    always_comb begin
        stall_hit    = (cls == AN_ONE) && (an_s2_q == an_prev_q) && !stall_lock_q
                       && (stall_cnt_q == TW'(STALL_CYCLES - 1));
        stall_cnt_d  = '0;
        if ((cls == AN_ONE) && (an_s2_q == an_prev_q) && !stall_lock_q && !stall_hit)
            stall_cnt_d = stall_cnt_q + 1'b1;
        stall_lock_d = stall_lock_q;
        if (stall_hit) stall_lock_d = 1'b1;
        else if (an_s2_q != an_prev_q) stall_lock_d = 1'b0;
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        ref_an_d      = ref_an_q;
        ref_ca_d      = ref_ca_q;
        idx_d         = idx_q;
        mask_d        = mask_q;
        anode_err_d   = anode_err_q;
        stall_err_d   = stall_err_q;
        wr_en         = 1'b0;
        load          = 1'b0;
        frame_valid_d = 1'b0;
        if (cls == AN_MULTI) begin
            anode_err_d = 1'b1;
            mask_d      = '0;
            state_d     = ST_IDLE;
        end else if (stall_hit) begin
            stall_err_d = 1'b1;
            mask_d      = '0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    load = (cls == AN_ONE) && !stall_lock_d;
                ST_SETTLE: begin
                    if (cls != AN_ONE) state_d = ST_IDLE;
                    else if (an_s2_q != ref_an_q || ca_s2_q != ref_ca_q) load = 1'b1;
                    else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) state_d = ST_CAPTURE;
                    else settle_cnt_d = settle_cnt_q + 1'b1;
                end
                ST_CAPTURE: begin
                    if (an_s2_q != ref_an_q || ca_s2_q != ref_ca_q) begin
                        if (cls == AN_ONE) load = 1'b1;
                        else state_d = ST_IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        mask_d  = mask_q | (DIGITS'(1) << idx_q);
                        state_d = ST_HOLD;
                        if (&mask_d) begin
                            frame_valid_d = 1'b1;
                            mask_d        = '0;
                        end
                    end
                end
                default: begin
                    if (cls != AN_ONE) state_d = ST_IDLE;
                    else if (an_s2_q != ref_an_q) load = 1'b1;
                end
            endcase
        end
        if (load) begin
            ref_an_d     = an_s2_q;
            ref_ca_d     = ca_s2_q;
            idx_d        = hit_idx;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
        end
    end

    // The publishing frame includes the slot written in the same cycle.
    always_comb begin
        buf_hex_d   = buf_hex_q;
        buf_dp_d    = buf_dp_q;
        buf_blank_d = buf_blank_q;
        buf_bad_d   = buf_bad_q;
        if (wr_en) begin
            buf_hex_d[{idx_q, 2'b00} +: 4] = dec_nib;
            buf_dp_d[idx_q]                = ~ca_s2_q[7];
            buf_blank_d[idx_q]             = dec_blank;
            buf_bad_d[idx_q]               = dec_bad;
        end
        frame_hex_d   = frame_valid_d ? buf_hex_d   : frame_hex_q;
        frame_dp_d    = frame_valid_d ? buf_dp_d    : frame_dp_q;
        frame_blank_d = frame_valid_d ? buf_blank_d : frame_blank_q;
        frame_bad_d   = frame_valid_d ? buf_bad_d   : frame_bad_q;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset_button) begin
            an_s1_q <= '1; an_s2_q <= '1; an_prev_q <= '1; ref_an_q <= '1;
            ca_s1_q <= '1; ca_s2_q <= '1; ref_ca_q <= '1;
            idx_q <= '0; state_q <= ST_IDLE; settle_cnt_q <= '0; stall_cnt_q <= '0;
            stall_lock_q <= 1'b0; mask_q <= '0;
            buf_hex_q <= '0; buf_dp_q <= '0; buf_blank_q <= '0; buf_bad_q <= '0;
            frame_hex_q <= '0; frame_dp_q <= '0; frame_blank_q <= '0; frame_bad_q <= '0;
            frame_valid_q <= 1'b0; anode_err_q <= 1'b0; stall_err_q <= 1'b0;
        end else begin
            an_s1_q <= anodes;   an_s2_q <= an_s1_q;   an_prev_q <= an_s2_q;
            ca_s1_q <= cathodes; ca_s2_q <= ca_s1_q;
            ref_an_q <= ref_an_d; ref_ca_q <= ref_ca_d; idx_q <= idx_d;
            state_q <= state_d; settle_cnt_q <= settle_cnt_d; stall_cnt_q <= stall_cnt_d;
            stall_lock_q <= stall_lock_d; mask_q <= mask_d;
            buf_hex_q <= buf_hex_d; buf_dp_q <= buf_dp_d;
            buf_blank_q <= buf_blank_d; buf_bad_q <= buf_bad_d;
            frame_hex_q <= frame_hex_d; frame_dp_q <= frame_dp_d;
            frame_blank_q <= frame_blank_d; frame_bad_q <= frame_bad_d;
            frame_valid_q <= frame_valid_d; anode_err_q <= anode_err_d; stall_err_q <= stall_err_d;
        end
    end

    assign frame_hex   = frame_hex_q;
    assign frame_dp    = frame_dp_q;
    assign frame_blank = frame_blank_q;
    assign frame_bad   = frame_bad_q;
    assign frame_valid = frame_valid_q;
    assign anode_err   = anode_err_q;
    assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with shortened settle/stall windows.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an, ca;
    logic [31:0] frame_hex;
    logic [7:0]  frame_dp, frame_blank, frame_bad;
    logic        frame_valid, anode_err, stall_err;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int fv0;
    logic [6:0] glyph [16];
    logic [6:0] pats  [8];
    logic [7:0] dp_mask;

    always #5 clk = ~clk;

    seg7_scan_capture #(.DIGITS(8), .SETTLE_CYCLES(10), .STALL_CYCLES(200)) dut (
        .clk_100MHz   (clk),
        .reset_button (rst),
        .anodes       (an),
        .cathodes     (ca),
        .frame_hex    (frame_hex),
        .frame_dp     (frame_dp),
        .frame_blank  (frame_blank),
        .frame_bad    (frame_bad),
        .frame_valid  (frame_valid),
        .anode_err    (anode_err),
        .stall_err    (stall_err)
    );

    always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int first, input int last, input int short_d);
        for (int d = first; d <= last; d++) begin
            an = ~(8'd1 << d);
            ca = {~dp_mask[d], pats[d]};
            idle((d == short_d) ? 5 : 40);
        end
    endtask

    task automatic release_an();
        an = 8'hFF;
        ca = 8'hFF;
        idle(20);
    endtask

    task automatic do_reset();
        an  = 8'hFF;
        ca  = 8'hFF;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic default_pats();
        for (int i = 0; i < 8; i++) pats[i] = glyph[i];
        dp_mask = 8'h00;
    endtask

    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
        default_pats();
        an  = 8'hFF;
        ca  = 8'hFF;
        rst = 1'b1;
        idle(3);
        check("rst_hex",   frame_hex,   32'h0);
        check("rst_dp",    frame_dp,    32'h0);
        check("rst_blank", frame_blank, 32'h0);
        check("rst_bad",   frame_bad,   32'h0);
        check("rst_valid", frame_valid, 32'h0);
        check("rst_aerr",  anode_err,   32'h0);
        check("rst_serr",  stall_err,   32'h0);
        rst = 1'b0;
        idle(2);

        // Plain scan 0..7
        fv0 = fv_cnt;
        scan(0, 7, -1);
        release_an();
        check("scan_fv",    fv_cnt - fv0, 32'd1);
        check("scan_hex",   frame_hex,    32'h76543210);
        check("scan_blank", frame_blank,  32'h0);
        check("scan_bad",   frame_bad,    32'h0);
        check("scan_dp",    frame_dp,     32'h0);
        check("scan_aerr",  anode_err,    32'h0);
        check("scan_serr",  stall_err,    32'h0);

        // Blank, invalid and dp digits
        pats[3] = 7'h7F;
        pats[5] = 7'h36;
        dp_mask = 8'h04;
        fv0 = fv_cnt;
        scan(0, 7, -1);
        release_an();
        check("mix_fv",    fv_cnt - fv0, 32'd1);
        check("mix_hex",   frame_hex,    32'h76040210);
        check("mix_blank", frame_blank,  32'h08);
        check("mix_bad",   frame_bad,    32'h20);
        check("mix_dp",    frame_dp,     32'h04);
        default_pats();

        // Short dwell on digit 4 leaves the frame incomplete
        fv0 = fv_cnt;
        scan(0, 7, 4);
        release_an();
        check("short_fv",    fv_cnt - fv0, 32'd0);
        check("short_hold",  frame_hex,    32'h76040210);
        scan(0, 7, -1);
        release_an();
        check("short2_fv",   fv_cnt - fv0, 32'd1);
        check("short2_hex",  frame_hex,    32'h76543210);
        check("short2_blank", frame_blank, 32'h0);
        check("short2_dp",   frame_dp,     32'h0);

        // Multiple anodes low mid-frame
        do_reset();
        fv0 = fv_cnt;
        scan(0, 3, -1);
        an = 8'hFC;
        ca = 8'hFF;
        idle(10);
        check("multi_aerr", anode_err, 32'h1);
        scan(4, 7, -1);
        release_an();
        check("multi_fv",    fv_cnt - fv0, 32'd0);
        check("multi_aerr2", anode_err,    32'h1);
        scan(0, 7, -1);
        release_an();
        check("multi2_fv",   fv_cnt - fv0, 32'd1);
        check("multi2_hex",  frame_hex,    32'h76543210);
        check("multi2_aerr", anode_err,    32'h1);

        // Stall on anode 0
        do_reset();
        check("stall_rst_aerr", anode_err, 32'h0);
        fv0 = fv_cnt;
        an = 8'hFE;
        ca = {1'b1, glyph[0]};
        idle(150);
        check("stall_early", stall_err, 32'h0);
        idle(100);
        check("stall_set",  stall_err,    32'h1);
        check("stall_fv",   fv_cnt - fv0, 32'd0);
        release_an();
        check("stall_sticky", stall_err, 32'h1);
        scan(0, 7, -1);
        release_an();
        check("stall_rearm_fv", fv_cnt - fv0, 32'd1);

        // Reset after five captured digits
        scan(0, 4, -1);
        an  = 8'hFF;
        ca  = 8'hFF;
        rst = 1'b1;
        idle(2);
        check("mrst_hex",   frame_hex,   32'h0);
        check("mrst_dp",    frame_dp,    32'h0);
        check("mrst_valid", frame_valid, 32'h0);
        check("mrst_aerr",  anode_err,   32'h0);
        check("mrst_serr",  stall_err,   32'h0);
        rst = 1'b0;
        idle(2);
        fv0 = fv_cnt;
        scan(5, 7, -1);
        release_an();
        check("mrst_partial_fv", fv_cnt - fv0, 32'd0);
        check("mrst_partial_hex", frame_hex,   32'h0);
        scan(0, 7, -1);
        release_an();
        check("mrst_full_fv",  fv_cnt - fv0, 32'd1);
        check("mrst_full_hex", frame_hex,    32'h76543210);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Passive receiver for the multiplexed 7-segment display interface: it samples the `anodes`/`cathodes` bus driven by the display scanner and decodes each digit pattern back to a hex nibble. It assembles complete 8-digit frames and publishes them with a one-cycle strobe. It serves as a self-check monitor on the board (ILA/LED readback) and as the synthesizable checker the level-meter benches instantiate instead of hand-decoding segment bits.

## Interface
- `DIGITS`, 8: number of anode lines / frame slots.
- `SETTLE_CYCLES`, 1000: cycles anode+cathode must be stable before capture (10 µs at 100 MHz).
- `STALL_CYCLES`, 200_000: maximum cycles one anode may stay active before a stall error (2 ms).

- `clk_100MHz` in 1: sole clock.
- `reset_button` in 1: synchronous, active-high reset.
- `anodes` in 8: digit enables, active-low, at most one low.
- `cathodes` in 8: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `frame_hex` out 32: nibble per digit; digit i at [4i+3:4i].
- `frame_dp` out 8: decimal point per digit (1 = lit).
- `frame_blank` out 8: digit had all segments a–g off.
- `frame_bad` out 8: pattern is neither hex 0–F nor blank; nibble forced to 0.
- `frame_valid` out 1: one-cycle pulse when all frame_* outputs update.
- `anode_err` out 1: sticky; more than one anode low was seen.
- `stall_err` out 1: sticky; one anode stayed active longer than STALL_CYCLES.

## Operation
- Inputs pass through a 2-flop register stage before any use.
- Anode state classification: *none* (all high), *one* (exactly one low, giving index i), *multi* (more than one low).
- FSM states:
  - IDLE: waits for *one*, then loads i and goes to SETTLE.
  - SETTLE: counts stable cycles. On any change of anode or cathode value, the counter restarts. At count SETTLE_CYCLES-1 the FSM goes to CAPTURE.
  - CAPTURE: lasts one cycle. Writes the decoded digit into slot i and sets mask bit i, then goes to HOLD.
  - HOLD: waits for the anode value to change. Change to *none* returns to IDLE. Change to *one* with a new index loads it and goes to SETTLE.
- *multi* in any state: set `anode_err`, clear mask, go to IDLE.
- Stall counter runs while the same anode stays *one*. Reaching STALL_CYCLES sets `stall_err`, clears mask and goes to IDLE; the FSM re-arms only after the anode changes.
- Re-capturing an already-masked slot overwrites it.
- When the mask becomes all-ones: copy the slot buffer to the frame_* outputs, pulse `frame_valid`, clear the mask.
- Decode uses the active-low pattern on segments a–g (dp ignored for value). Standard hex glyphs are used, with lowercase b and d. 0x7F is blank. All other patterns are bad.

## Timing
- Reset: all outputs 0, mask 0, FSM in IDLE, counters 0, sticky errors cleared. Reset is the only way to clear the sticky errors.
- Input to internal latency: 2 cycles.
- Capture occurs SETTLE_CYCLES cycles after the last input change, as seen after synchronization.
- `frame_valid` asserts in the cycle after the CAPTURE that fills the mask. frame_* outputs change only in that same cycle and hold otherwise.
- Minimum digit dwell for capture: SETTLE_CYCLES+2 cycles. Shorter dwells are silently skipped and the frame stays incomplete.
- If a CAPTURE and a *multi* detection fall in the same cycle, the error wins: no write, mask cleared.
- Reset asserted mid-frame discards the partial frame; no `frame_valid` is issued.

## Structure
- Package `seg7_pkg`:
  - the 16 hex glyph constants and the BLANK constant;
  - the FSM state enum {IDLE, SETTLE, CAPTURE, HOLD};
  - the anode-class enum.
- Sub-module `seg7_decode`: combinational mapping from pattern to {nibble, blank, bad}. It is shared with the display encoder tests.
- Top level holds the sync stage, the FSM, both counters, the 8-entry slot buffer and the output registers.

## Test plan
- Scan digits 0–7 showing 0,1,…,7, dwell 50_000 cycles each → one `frame_valid`, frame_hex=0x76543210, blank/bad/errors 0.
- Digit 3 shows pattern 0x7F, digit 5 shows 0x36 (invalid), digit 2 dp lit → frame_blank=0x08, frame_bad=0x20, frame_dp=0x04, frame_hex nibble 5 = 0.
- Digit 4 dwell of 500 cycles → no `frame_valid` that scan; next full scan → valid frame.
- Anodes=0xFC for 10 cycles mid-frame → `anode_err`=1 and stays set, partial frame discarded, next complete scan publishes.
- Hold anode 0 low for 250_000 cycles → `stall_err`=1 at cycle 200_000 after activation, no frame.
- Reset pulsed after 5 digits captured → outputs and errors 0, no `frame_valid` until a fresh complete scan.
